// File: rtl/tmp3_bcd_pkg.sv
// Shared types and constants for the TMP3 temperature-to-BCD formatter.
package tmp3_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV_INT  = 2'd1,
    CONV_FRAC = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int TEMP_W     = 12;
  localparam int INT_W      = 8;
  localparam int FRAC_W     = 14;
  localparam int DIGIT_W    = 4;
  localparam int FRAC_SCALE = 625;
  localparam int ACC_DIGITS = 4;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/tmp3_bcd_formatter_bcd_shift_add.sv
// Iterative double-dabble engine: loads on start, shifts nshift times MSB first,
// done is high while the shift counter is exhausted.
module bcd_shift_add #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       operand,
  input  logic [CNT_W-1:0]      nshift,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [IN_W-1:0]     sh;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] adj;

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj  = add3(bcd);
  assign done = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= nshift;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Narrow operands are left-aligned by the caller so the MSB leads the shift.
  always_ff @(posedge clk) begin
    if (start) begin
      sh  <= operand;
      bcd <= '0;
    end else if (cnt != '0) begin
      bcd <= {adj[4*DIGITS-2:0], sh[IN_W-1]};
      sh  <= {sh[IN_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/tmp3_bcd_formatter.sv
// Converts TMP3 12-bit two's-complement temperature into sign + BCD integer/fraction.
// Optional running min/max tracking is enabled with the TMP3_BCD_MINMAX_EN macro.
module tmp3_bcd_formatter
  import tmp3_bcd_pkg::*;
#(
  parameter int FRAC_DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [TEMP_W-1:0]        temperature_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic                     sign_o,
  output logic [11:0]              int_bcd_o,
  output logic [4*FRAC_DIGITS-1:0] frac_bcd_o,
  output logic                     overrun_o,
  input  logic                     clear_overrun
`ifdef TMP3_BCD_MINMAX_EN
  ,
  input  logic                     clear_minmax,
  output logic [TEMP_W-1:0]        min_o,
  output logic [TEMP_W-1:0]        max_o
`endif
);

  state_t                     state, state_nx;
  logic                       valid_d, new_smp, capture;
  logic                       pend_full;
  logic [TEMP_W-1:0]          pend_temp, cap_temp, mag;
  logic [INT_W-1:0]           cap_int;
  logic [FRAC_W-1:0]          cap_frac, frac_lat;
  logic                       sign_lat;
  logic [11:0]                int_res;
  logic                       eng_start, eng_done;
  logic [FRAC_W-1:0]          eng_op;
  logic [CNT_W-1:0]           eng_n;
  logic [DIGIT_W*ACC_DIGITS-1:0] eng_bcd;

  assign new_smp  = valid_i & ~valid_d;
  assign capture  = (state == IDLE) && (new_smp || pend_full);
  assign cap_temp = new_smp ? temperature_i : pend_temp;
  assign mag      = cap_temp[TEMP_W-1] ? (~cap_temp + 12'd1) : cap_temp;
  assign cap_int  = mag[TEMP_W-1:4];
  assign cap_frac = FRAC_W'(mag[3:0]) * FRAC_W'(FRAC_SCALE);
  assign busy_o   = (state == CONV_INT) || (state == CONV_FRAC);

  always_comb begin
    state_nx  = state;
    eng_start = 1'b0;
    eng_op    = '0;
    eng_n     = '0;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nx  = CONV_INT;
          eng_start = 1'b1;
          eng_op    = {cap_int, {(FRAC_W-INT_W){1'b0}}};
          eng_n     = CNT_W'(INT_W);
        end
      end
      CONV_INT: begin
        if (eng_done) begin
          state_nx  = CONV_FRAC;
          eng_start = 1'b1;
          eng_op    = frac_lat;
          eng_n     = CNT_W'(FRAC_W);
        end
      end
      CONV_FRAC: begin
        if (eng_done) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  bcd_shift_add #(
    .IN_W  (FRAC_W),
    .DIGITS(ACC_DIGITS),
    .CNT_W (CNT_W)
  ) u_eng (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .operand(eng_op),
    .nshift (eng_n),
    .done   (eng_done),
    .bcd    (eng_bcd)
  );

  always_ff @(posedge clk) begin
    if (capture) begin
      sign_lat <= cap_temp[TEMP_W-1];
      frac_lat <= cap_frac;
    end
    if (state == CONV_INT && eng_done) int_res <= eng_bcd[11:0];
    if (new_smp && state != IDLE) pend_temp <= temperature_i;
  end

  // Results land on the edge entering DONE so valid_o is high during DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid_d    <= 1'b0;
      pend_full  <= 1'b0;
      overrun_o  <= 1'b0;
      valid_o    <= 1'b0;
      sign_o     <= 1'b0;
      int_bcd_o  <= '0;
      frac_bcd_o <= '0;
    end else begin
      state   <= state_nx;
      valid_d <= valid_i;
      valid_o <= 1'b0;
      if (state == CONV_FRAC && eng_done) begin
        valid_o    <= 1'b1;
        sign_o     <= sign_lat;
        int_bcd_o  <= int_res;
        frac_bcd_o <= eng_bcd[DIGIT_W*ACC_DIGITS-1 -: 4*FRAC_DIGITS];
      end
      if (new_smp && state != IDLE) pend_full <= 1'b1;
      else if (capture)             pend_full <= 1'b0;
      if (new_smp && state != IDLE && pend_full) overrun_o <= 1'b1;
      else if (clear_overrun)                    overrun_o <= 1'b0;
    end
  end

`ifdef TMP3_BCD_MINMAX_EN
  logic mm_loaded;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mm_loaded <= 1'b0;
      min_o     <= '0;
      max_o     <= '0;
    end else if (capture) begin
      mm_loaded <= 1'b1;
      if (!mm_loaded || clear_minmax) begin
        min_o <= cap_temp;
        max_o <= cap_temp;
      end else begin
        if ($signed(cap_temp) < $signed(min_o)) min_o <= cap_temp;
        if ($signed(cap_temp) > $signed(max_o)) max_o <= cap_temp;
      end
    end else if (clear_minmax) begin
      mm_loaded <= 1'b0;
    end
  end
`endif

endmodule
